// File: rtl/picomem_host_master_pkg.sv
// Shared types and constants for the picorv32 host-link bus master.
// Opcodes, default response bytes and the frame FSM state encoding.
package picomem_host_pkg;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  localparam logic [7:0] ACK_DEF = 8'hAA;
  localparam logic [7:0] ERR_DEF = 8'hEE;

  typedef enum logic [2:0] {
    S_OP,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  // A write opcode with a zero strobe nibble means a full-word write
  function automatic logic [3:0] wr_strb(input logic [3:0] f);
    return (f == 4'h0) ? 4'hF : f;
  endfunction

endpackage

// File: rtl/picomem_host_master_if.sv
// Host byte link plus picorv32 native memory bus, seen from the master.
// The slave modport is the host FIFO and memory responder side.
interface picomem_host_master_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    input  mem_ready, mem_rdata,
    output rx_ready, tx_data, tx_valid,
    output mem_valid, mem_instr,
    output mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    output mem_ready, mem_rdata,
    input  rx_ready, tx_data, tx_valid,
    input  mem_valid, mem_instr,
    input  mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/picomem_host_master_byte_shift.sv
// 32-bit little-endian byte shifter: bytes enter at the top and
// leave from the bottom, so both directions are LSB first.
module picomem_byte_shift (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_data,
  input  logic        i_shift_in,
  input  logic [7:0]  i_byte,
  input  logic        i_shift_out,
  output logic [31:0] o_word,
  output logic [7:0]  o_byte
);

  logic [31:0] r_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_load_data;
    end else if (i_shift_in) begin
      r_word <= {i_byte, r_word[31:8]};
    end else if (i_shift_out) begin
      r_word <= {8'h00, r_word[31:8]};
    end
  end

  assign o_word = r_word;
  assign o_byte = r_word[7:0];

endmodule

// File: rtl/picomem_host_master.sv
// Turns host command frames into single-word picorv32 bus transfers
// and streams the read data, ACK or ERR byte back to the host.
module picomem_host_master
  import picomem_host_pkg::*;
#(
  parameter logic [7:0] TIMEOUT  = 8'd255,
  parameter logic [7:0] ACK_BYTE = ACK_DEF,
  parameter logic [7:0] ERR_BYTE = ERR_DEF
) (
  input  logic clk,
  input  logic reset,
  picomem_host_master_if.master bus,
  output logic busy,
  output logic timeout_flag
);

  state_t      r_state, w_next;
  logic [1:0]  r_cnt, r_last;
  logic [7:0]  r_tcnt;
  logic        r_rd, r_tflag;
  logic [3:0]  r_strb, r_wstrb;
  logic [31:0] r_addr, r_wdata;

  logic        w_rx_fire, w_tx_fire;
  logic        w_op_rd, w_op_wr;
  logic        w_tout;
  logic [7:0]  w_tnext;
  logic        w_in_clr, w_in_sh;
  logic        w_addr_cap, w_data_cap;
  logic        w_rsp_ld, w_tx_sh, w_tout_hit;
  logic [31:0] w_rsp_word;
  logic [1:0]  w_rsp_last;
  logic [31:0] w_in_word, w_out_word;
  logic [7:0]  w_in_byte, w_out_byte;
  logic        w_unused;

  assign w_rx_fire = bus.rx_valid & bus.rx_ready;
  assign w_tx_fire = bus.tx_valid & bus.tx_ready;
  assign w_op_rd   = (bus.rx_data[3:0] == OP_READ);
  assign w_op_wr   = (bus.rx_data[3:0] == OP_WRITE);
  assign w_tnext   = r_tcnt + 8'd1;
  assign w_tout    = (w_tnext == TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_OP;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_clr   = 1'b0;
    w_in_sh    = 1'b0;
    w_addr_cap = 1'b0;
    w_data_cap = 1'b0;
    w_rsp_ld   = 1'b0;
    w_rsp_word = 32'h0;
    w_rsp_last = 2'd0;
    w_tx_sh    = 1'b0;
    w_tout_hit = 1'b0;
    unique case (r_state)
      S_OP: begin
        if (w_rx_fire) begin
          if (w_op_rd || w_op_wr) begin
            w_next   = S_ADDR;
            w_in_clr = 1'b1;
          end else begin
            w_next     = S_RESP;
            w_rsp_ld   = 1'b1;
            w_rsp_word = {24'h0, ERR_BYTE};
          end
        end
      end
      S_ADDR: begin
        if (w_rx_fire) begin
          w_in_sh = 1'b1;
          if (r_cnt == 2'd3) begin
            w_addr_cap = 1'b1;
            w_next     = r_rd ? S_BUS : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_rx_fire) begin
          w_in_sh = 1'b1;
          if (r_cnt == 2'd3) begin
            w_data_cap = 1'b1;
            w_next     = S_BUS;
          end
        end
      end
      S_BUS: begin
        // A ready on the terminal count still completes the transfer
        if (bus.mem_ready) begin
          w_next     = S_RESP;
          w_rsp_ld   = 1'b1;
          w_rsp_word = r_rd ? bus.mem_rdata : {24'h0, ACK_BYTE};
          w_rsp_last = r_rd ? 2'd3 : 2'd0;
        end else if (w_tout) begin
          w_next     = S_RESP;
          w_rsp_ld   = 1'b1;
          w_rsp_word = {24'h0, ERR_BYTE};
          w_tout_hit = 1'b1;
        end
      end
      S_RESP: begin
        if (w_tx_fire) begin
          if (r_cnt == r_last) w_next = S_OP;
          else                 w_tx_sh = 1'b1;
        end
      end
      default: w_next = S_OP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_last  <= '0;
      r_tcnt  <= '0;
      r_rd    <= 1'b0;
      r_strb  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_tflag <= 1'b0;
    end else begin
      if (w_next != r_state)      r_cnt <= '0;
      else if (w_in_sh || w_tx_sh) r_cnt <= r_cnt + 2'd1;
      if (r_state != S_BUS) r_tcnt <= '0;
      else                  r_tcnt <= w_tnext;
      if (w_in_clr) begin
        r_rd   <= w_op_rd;
        r_strb <= w_op_rd ? 4'h0 : wr_strb(bus.rx_data[7:4]);
      end
      if (w_addr_cap) begin
        r_addr  <= {bus.rx_data, w_in_word[31:10], 2'b00};
        r_wstrb <= r_strb;
      end
      if (w_data_cap) r_wdata <= {bus.rx_data, w_in_word[31:8]};
      if (w_rsp_ld)   r_last  <= w_rsp_last;
      if (w_tout_hit) r_tflag <= 1'b1;
    end
  end

  picomem_byte_shift u_in_shift (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_in_clr),
    .i_load_data(32'h0),
    .i_shift_in (w_in_sh),
    .i_byte     (bus.rx_data),
    .i_shift_out(1'b0),
    .o_word     (w_in_word),
    .o_byte     (w_in_byte)
  );

  picomem_byte_shift u_out_shift (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rsp_ld),
    .i_load_data(w_rsp_word),
    .i_shift_in (1'b0),
    .i_byte     (8'h00),
    .i_shift_out(w_tx_sh),
    .o_word     (w_out_word),
    .o_byte     (w_out_byte)
  );

  assign w_unused = ^{w_in_word[7:0], w_in_byte, w_out_word};

  assign bus.rx_ready  = ~reset & ((r_state == S_OP) |
                                   (r_state == S_ADDR) |
                                   (r_state == S_DATA));
  assign bus.tx_valid  = (r_state == S_RESP);
  assign bus.tx_data   = w_out_byte;
  assign bus.mem_valid = (r_state == S_BUS);
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;
  assign busy          = (r_state != S_OP);
  assign timeout_flag  = r_tflag;

endmodule

// File: tb/tb_picomem_host_master.sv
// Directed bench: host frames in, memory responder with variable
// latency, response bytes checked against hand-computed values.
module tb_picomem_host_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, tflag;

  int n_tests = 0;
  int n_fail = 0;
  int stall_err = 0;
  int lat = 0;
  int wcnt = 0;
  int vtotal = 0;

  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [31:0] mem [0:15];

  picomem_host_master_if ifc();

  picomem_host_master #(.TIMEOUT(8'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifc),
    .busy        (busy),
    .timeout_flag(tflag)
  );

  always #5 clk = ~clk;

  // Responder: ready after 'lat' waiting cycles, never when lat < 0
  assign ifc.mem_ready = ifc.mem_valid && (lat >= 0) && (wcnt >= lat);
  assign ifc.mem_rdata = mem[ifc.mem_addr[5:2]];

  always @(posedge clk) begin
    if (ifc.mem_valid && !ifc.mem_ready) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
    if (ifc.mem_valid && ifc.mem_ready)
      for (int b = 0; b < 4; b++)
        if (ifc.mem_wstrb[b])
          mem[ifc.mem_addr[5:2]][8*b +: 8] <= ifc.mem_wdata[8*b +: 8];
  end

  always @(negedge clk) begin
    if (ifc.mem_valid) begin
      vtotal    <= vtotal + 1;
      cap_addr  <= ifc.mem_addr;
      cap_wdata <= ifc.mem_wdata;
      cap_wstrb <= ifc.mem_wstrb;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    while (!ifc.rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("rx_wait", {31'b0, ifc.rx_ready}, 32'd1);
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic recv(input int n, input int stall,
                      output logic [31:0] w);
    int k;
    logic [7:0] d;
    w = '0;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!ifc.tx_valid && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) begin
        chk("tx_wait", {31'b0, ifc.tx_valid}, 32'd1);
        return;
      end
      for (int s = 0; s < stall; s++) begin
        d = ifc.tx_data;
        @(negedge clk);
        if (!ifc.tx_valid || ifc.tx_data !== d || ifc.rx_ready)
          stall_err++;
      end
      ifc.tx_ready = 1'b1;
      w[8*i +: 8] = ifc.tx_data;
      @(negedge clk);
      ifc.tx_ready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int n_b,
                         input int stall, output logic [31:0] w);
    send_byte(8'h01);
    send4(a);
    recv(n_b, stall, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int v0;
    int k;
    ifc.rx_data  = 8'h00;
    ifc.rx_valid = 1'b0;
    ifc.tx_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {ifc.mem_valid, ifc.rx_ready, ifc.tx_valid,
                     busy, tflag, ifc.mem_instr}, 32'd0);
    chk("rst_addr", ifc.mem_addr, 32'd0);
    chk("rst_wdata", ifc.mem_wdata, 32'd0);
    chk("rst_tx", {ifc.mem_wstrb, ifc.tx_data}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_rx_ready", {31'b0, ifc.rx_ready}, 32'd1);

    v0 = vtotal;
    send_byte(8'h02);
    send4(32'h0000_0010);
    send4(32'h1234_5678);
    recv(1, 0, w);
    chk("wr_ack", w, 32'h0000_00AA);
    chk("wr_addr", cap_addr, 32'h0000_0010);
    chk("wr_wstrb", {28'b0, cap_wstrb}, 32'hF);
    chk("wr_wdata", cap_wdata, 32'h1234_5678);
    chk("wr_vcyc", vtotal - v0, 32'd1);

    do_read(32'h0000_0010, 4, 0, w);
    chk("rd_data", w, 32'h1234_5678);
    chk("rd_wstrb", {28'b0, cap_wstrb}, 32'h0);

    send_byte(8'h22);
    send4(32'h0000_0013);
    send4(32'hDEAD_BEEF);
    recv(1, 0, w);
    chk("bs_ack", w, 32'h0000_00AA);
    chk("bs_addr", cap_addr, 32'h0000_0010);
    chk("bs_wstrb", {28'b0, cap_wstrb}, 32'h2);
    do_read(32'h0000_0010, 4, 0, w);
    chk("bs_rdback", w, 32'h1234_BE78);

    lat = 2;
    v0 = vtotal;
    do_read(32'h0000_0010, 4, 0, w);
    chk("slow_data", w, 32'h1234_BE78);
    chk("slow_vcyc", vtotal - v0, 32'd3);

    lat = -1;
    v0 = vtotal;
    do_read(32'h0000_0020, 1, 0, w);
    chk("to_err", w, 32'h0000_00EE);
    chk("to_vcyc", vtotal - v0, 32'd8);
    chk("to_flag", {31'b0, tflag}, 32'd1);

    lat = 0;
    v0 = vtotal;
    send_byte(8'h07);
    recv(1, 0, w);
    chk("bad_err", w, 32'h0000_00EE);
    chk("bad_vcyc", vtotal - v0, 32'd0);
    do_read(32'h0000_0010, 4, 0, w);
    chk("bad_next_op", w, 32'h1234_BE78);

    do_read(32'h0000_0010, 4, 5, w);
    chk("bp_data", w, 32'h1234_BE78);
    chk("bp_stable", stall_err, 32'd0);

    lat = -1;
    send_byte(8'h01);
    send4(32'h0000_0010);
    k = 0;
    while (!ifc.mem_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mr_bus", {31'b0, ifc.mem_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_valid", {31'b0, ifc.mem_valid}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_rx_ready", {31'b0, ifc.rx_ready}, 32'd1);
    chk("mr_flag", {31'b0, tflag}, 32'd0);
    lat = 0;
    do_read(32'h0000_0010, 4, 0, w);
    chk("mr_after", w, 32'h1234_BE78);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
